mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl -- E-stage controller for a multi-cycle multiply/divide unit.
//
// Decides when an MDU-class instruction in E may proceed, issues mult/div
// operations to the MDU, steers mthi/mtlo writes, and returns mfhi/mflo data.
// A small FSM tracks an issued operation until the MDU drops Busy.
//
// Ports
//   Clk, Reset          sole clock (rising edge), synchronous active-high reset
//   InstrValid          E-stage instruction valid
//   MDUClass[2:0]       0 none, 1 mult, 2 div, 3 mthi, 4 mtlo, 5 mfhi, 6 mflo,
//                       7 reserved (treated as none)
//   MDUOpIn[1:0]        00 MULU, 01 MUL, 10 DIVU, 11 DIV
//   RsData, RtData      forwarded E-stage operands
//   FlushE              kill the E-stage instruction
//   Busy                MDU busy (rises the cycle after Start, falls on commit)
//   HI, LO              MDU architectural registers
//   Start, HIWrite, LOWrite   MDU controls
//   MDUOp, A, B         operation and operands passed through to the MDU
//   Stall               freeze F/D/E, bubble M
//   MFResult            mfhi/mflo data for the E-stage result mux
//   Error               sticky protocol fault
//   StallCnt            number of cycles spent with Stall=1 (wraps)
// ---------------------------------------------------------------------------
module mdu_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        InstrValid,
    input  logic [2:0]  MDUClass,
    input  logic [1:0]  MDUOpIn,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic        FlushE,
    input  logic        Busy,
    input  logic [31:0] HI,
    input  logic [31:0] LO,
    output logic        Start,
    output logic        HIWrite,
    output logic        LOWrite,
    output logic [1:0]  MDUOp,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic        Stall,
    output logic [31:0] MFResult,
    output logic        Error,
    output logic [31:0] StallCnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUED = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        error_reg;
    logic        error_next;
    logic [31:0] stall_cnt_reg;

    // One-hot decode of the instruction class.
    logic [7:0] class_hot;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_class_dec
            assign class_hot[gi] = (MDUClass == 3'(gi));
        end
    endgenerate

    logic act;
    logic go;

    // Operands and operation go straight to the MDU; Start qualifies them.
    assign MDUOp    = MDUOpIn;
    assign A        = RsData;
    assign B        = RtData;
    assign Error    = error_reg;
    assign StallCnt = stall_cnt_reg;

    always_comb begin
        act      = InstrValid & ~FlushE & (|class_hot[6:1]);
        // Any MDU instruction waits while an operation is outstanding or the
        // MDU reports busy (including a stray busy seen while idle).
        Stall    = act & ((state_reg != IDLE) | Busy);
        // Reset suppresses every control strobe so the MDU sees nothing
        // while both blocks are being reset.
        go       = act & ~Stall & ~Reset;
        Start    = go & (class_hot[1] | class_hot[2]);
        HIWrite  = go & class_hot[3];
        LOWrite  = go & class_hot[4];
        MFResult = class_hot[5] ? HI : (class_hot[6] ? LO : 32'd0);
    end

    always_comb begin
        state_next = state_reg;
        error_next = error_reg;
        case (state_reg)
            IDLE: begin
                // Busy with nothing issued is a protocol fault.
                if (Busy) begin
                    error_next = 1'b1;
                end
                if (Start) begin
                    state_next = ISSUED;
                end
            end
            ISSUED: begin
                // The MDU must answer a Start with Busy on the next cycle.
                if (Busy) begin
                    state_next = RUN;
                end else begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (!Busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= IDLE;
            error_reg     <= 1'b0;
            stall_cnt_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            error_reg <= error_next;
            if (Stall) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

endmodule
